// File: rtl/vga_scan_driver_if.sv
// ---------------------------------------------------------------------------
// vga_scan_driver_if
//   Bundle of every signal between the VGA scan driver, the visualizer that
//   colours the pixels, and the DE2-70 VGA DAC pins.
//
//   master : the scan driver. It takes the pixel tick and the visualizer
//            colour, and drives the coordinates, frame sync and DAC pins.
//   slave  : the environment. It drives the pixel tick and colour, and
//            consumes the coordinates and DAC pins.
//
//   iEn                  pixel tick
//   iR, iG, iB           10-bit colour from the visualizer
//   oX, oY               current pixel coordinate (0 outside the active area)
//   oFS                  frame sync, high during active lines
//   oFrameTick           one-clock pulse at frame wrap
//   oVGA_R/G/B           DAC colour
//   oVGA_HS, oVGA_VS     sync outputs
//   oVGA_BLANK_N         high in the active region
//   oVGA_SYNC_N          tied low (no sync-on-green)
// ---------------------------------------------------------------------------
interface vga_scan_driver_if;
   logic       iEn;
   logic [9:0] iR;
   logic [9:0] iG;
   logic [9:0] iB;
   logic [9:0] oX;
   logic [9:0] oY;
   logic       oFS;
   logic       oFrameTick;
   logic [9:0] oVGA_R;
   logic [9:0] oVGA_G;
   logic [9:0] oVGA_B;
   logic       oVGA_HS;
   logic       oVGA_VS;
   logic       oVGA_BLANK_N;
   logic       oVGA_SYNC_N;

   modport master (
      input  iEn, iR, iG, iB,
      output oX, oY, oFS, oFrameTick,
             oVGA_R, oVGA_G, oVGA_B,
             oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_SYNC_N
   );

   modport slave (
      output iEn, iR, iG, iB,
      input  oX, oY, oFS, oFrameTick,
             oVGA_R, oVGA_G, oVGA_B,
             oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_SYNC_N
   );
endinterface

// File: rtl/vga_scan_driver.sv
// ---------------------------------------------------------------------------
// vga_scan_driver
//   Raster scan generator for one display pipeline. It walks the pixel
//   counters, hands the active pixel coordinate to the visualizer, and puts
//   the returned colour on the VGA DAC. HS/VS/BLANK are delayed so that they
//   stay aligned with that colour.
//
//   Ports
//     iCLK   system clock
//     iRST   synchronous active-high reset (takes priority over iEn)
//     bus    vga_scan_driver_if.master (pixel tick, visualizer colour in;
//            coordinates, frame sync and DAC pins out)
//
//   Timing
//     Coordinates are combinational from the counters. The visualizer
//     returns colour PIPE ticks later. The control triple {act, hs, vs} is
//     delayed by PIPE ticks to match it, and one output register follows.
//     Counter-to-pin latency is therefore PIPE+1 ticks for both colour and
//     control.
// ---------------------------------------------------------------------------
module vga_scan_driver #(
   parameter int H_ACT    = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACT    = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int PIPE     = 0,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic              iCLK,
   input  logic              iRST,
   vga_scan_driver_if.master bus
);

   localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT_W    = 10'(H_ACT);
   localparam logic [9:0] V_ACT_W    = 10'(V_ACT);
   localparam logic [9:0] H_SYNC_BEG = 10'(H_ACT + H_FP);
   localparam logic [9:0] H_SYNC_END = 10'(H_ACT + H_FP + H_SYNC);
   localparam logic [9:0] V_SYNC_BEG = 10'(V_ACT + V_FP);
   localparam logic [9:0] V_SYNC_END = 10'(V_ACT + V_FP + V_SYNC);

   // The counters are 10 bits wide, so every timing sum has to fit in them.
   generate
      if (H_TOTAL > 1023 || V_TOTAL > 1023 || PIPE < 0 || PIPE > 7) begin : g_badParams
         $error("vga_scan_driver: timing sums must be <= 1023 and PIPE within 0..7");
      end
   endgenerate

   // ---------------------------------------------------------------- counters
   logic [9:0] hcntReg, hcntNext;
   logic [9:0] vcntReg, vcntNext;

   always_comb begin
      hcntNext = hcntReg;
      vcntNext = vcntReg;
      if (bus.iEn) begin
         if (hcntReg == H_LAST) begin
            hcntNext = '0;
            vcntNext = (vcntReg == V_LAST) ? '0 : vcntReg + 10'd1;
         end else begin
            hcntNext = hcntReg + 10'd1;
         end
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         hcntReg <= '0;
         vcntReg <= '0;
      end else begin
         hcntReg <= hcntNext;
         vcntReg <= vcntNext;
      end
   end

   // ---------------------------------------------------------- region decode
   logic act, hsAct, vsAct;

   assign act   = (hcntReg < H_ACT_W) && (vcntReg < V_ACT_W);
   assign hsAct = (hcntReg >= H_SYNC_BEG) && (hcntReg < H_SYNC_END);
   assign vsAct = (vcntReg >= V_SYNC_BEG) && (vcntReg < V_SYNC_END);

   assign bus.oX  = act ? hcntReg : '0;
   assign bus.oY  = act ? vcntReg : '0;
   assign bus.oFS = (vcntReg < V_ACT_W);

   // The tick leaves the last pixel of the frame. Reset suppresses it, so a
   // restart never reports a frame wrap.
   assign bus.oFrameTick = bus.iEn && !iRST && (hcntReg == H_LAST) && (vcntReg == V_LAST);

   // ------------------------------------------------------ control delay line
   // Bit order is {act, hs, vs}. On reset every stage is cleared, so stages
   // still draining after a restart read as blank with sync deasserted and
   // no runt sync pulse can reach the pins.
   logic [2:0] ctrlNow;
   logic [2:0] ctrlDly;

   assign ctrlNow = {act, hsAct, vsAct};

   generate
      if (PIPE == 0) begin : g_noDelay
         assign ctrlDly = ctrlNow;
      end else begin : g_delay
         for (genvar gi = 0; gi < PIPE; gi++) begin : g_stage
            logic [2:0] stageReg;
            logic [2:0] stageIn;

            if (gi == 0) begin : g_head
               assign stageIn = ctrlNow;
            end else begin : g_tail
               assign stageIn = g_stage[gi-1].stageReg;
            end

            always_ff @(posedge iCLK) begin
               if (iRST) begin
                  stageReg <= 3'b000;
               end else if (bus.iEn) begin
                  stageReg <= stageIn;
               end
            end
         end
         assign ctrlDly = g_stage[PIPE-1].stageReg;
      end
   endgenerate

   // --------------------------------------------------------- output register
   logic [9:0] rReg, gReg, bReg;
   logic       blankNReg, hsReg, vsReg;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         rReg      <= '0;
         gReg      <= '0;
         bReg      <= '0;
         blankNReg <= 1'b0;
         hsReg     <= ~SYNC_POL;
         vsReg     <= ~SYNC_POL;
      end else if (bus.iEn) begin
         rReg      <= ctrlDly[2] ? bus.iR : '0;
         gReg      <= ctrlDly[2] ? bus.iG : '0;
         bReg      <= ctrlDly[2] ? bus.iB : '0;
         blankNReg <= ctrlDly[2];
         hsReg     <= ctrlDly[1] ? SYNC_POL : ~SYNC_POL;
         vsReg     <= ctrlDly[0] ? SYNC_POL : ~SYNC_POL;
      end
   end

   assign bus.oVGA_R       = rReg;
   assign bus.oVGA_G       = gReg;
   assign bus.oVGA_B       = bReg;
   assign bus.oVGA_BLANK_N = blankNReg;
   assign bus.oVGA_HS      = hsReg;
   assign bus.oVGA_VS      = vsReg;
   assign bus.oVGA_SYNC_N  = 1'b0;

endmodule
